// File: rtl/intirvx_issue_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// intirvx_issue_dispatch_pkg
// Shared types for the issue/dispatch stage:
//   - unit encodings carried in the decode bus
//   - trap kind enum reported to the trap controller
//   - decode_bus payload produced by the decoder
//   - issue_entry_t, one buffered instruction (decode bus, PC, raw inst)
//   - dispatch FSM states and small classification helpers
// ----------------------------------------------------------------------------
package intirvx_issue_dispatch_pkg;

    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_LSU = 2'd1;
    localparam logic [1:0] UNIT_CSR = 2'd2;
    // Encoding 3 is not a real unit; the decoder uses it for "no unit",
    // which the dispatcher treats as an illegal instruction.
    localparam logic [1:0] UNIT_SYS = 2'd3;

    typedef enum logic [1:0] {
        TRAP_ILLEGAL = 2'd0,
        TRAP_EBREAK  = 2'd1,
        TRAP_ECALL   = 2'd2,
        TRAP_MRET    = 2'd3
    } trap_kind_e;

    typedef struct packed {
        logic [3:0] op;            // unit-specific operation select
        logic [1:0] unit;          // UNIT_* target
        logic       fence;         // fence or fence.i
        logic       imm;           // with fence: 1 = fence.i
        logic       ecall;
        logic       ebreak;
        logic       mret;
        logic       illegal_instr;
    } decode_bus;

    typedef struct packed {
        decode_bus   dec;
        logic [31:0] pc;
        logic [31:0] inst;
    } issue_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } disp_state_e;

    // Number of set bits in the 3-bit completion vector.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Entry must end in a trap request rather than a unit issue or fence.
    function automatic logic is_trap(input decode_bus d);
        return d.illegal_instr | d.ebreak | d.ecall | d.mret | (d.unit == UNIT_SYS);
    endfunction

    // Entry must be serialized (drain first, then fence pulse or trap).
    function automatic logic is_sys(input decode_bus d);
        return d.fence | is_trap(d);
    endfunction

    // Trap kind with priority illegal > ebreak > ecall > mret.
    function automatic trap_kind_e trap_kind_of(input decode_bus d);
        trap_kind_e k;
        if (d.illegal_instr || (d.unit == UNIT_SYS)) begin
            k = TRAP_ILLEGAL;
        end else if (d.ebreak) begin
            k = TRAP_EBREAK;
        end else if (d.ecall) begin
            k = TRAP_ECALL;
        end else begin
            k = TRAP_MRET;
        end
        return k;
    endfunction

endpackage

// File: rtl/intirvx_issue_dispatch_chk.sv
// ----------------------------------------------------------------------------
// intirvx_issue_dispatch_chk
// Protocol checks for the dispatcher:
//   - no completion pulse while nothing is outstanding
//   - at most one unit valid at a time
//   - a stalled unit request keeps its valid and payload until accepted
// Ports: observation-only copies of the dispatcher's signals.
// ----------------------------------------------------------------------------
module intirvx_issue_dispatch_chk #(
    parameter int CNT_W = 3,
    parameter int PAY_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush_i,
    input logic [CNT_W-1:0] cnt_i,
    input logic [2:0]       done_i,
    input logic             alu_valid_i,
    input logic             alu_ready_i,
    input logic             lsu_valid_i,
    input logic             lsu_ready_i,
    input logic             csr_valid_i,
    input logic             csr_ready_i,
    input logic [PAY_W-1:0] payload_i
);

    logic stall_s;

    assign stall_s = (alu_valid_i && !alu_ready_i) ||
                     (lsu_valid_i && !lsu_ready_i) ||
                     (csr_valid_i && !csr_ready_i);

    a_no_done_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !((cnt_i == {CNT_W{1'b0}}) && (|done_i)));

    a_one_unit_valid: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({alu_valid_i, lsu_valid_i, csr_valid_i}));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (stall_s && !flush_i) |=> $stable({alu_valid_i, lsu_valid_i, csr_valid_i, payload_i}));

endmodule

// File: rtl/intirvx_issue_fifo.sv
// ----------------------------------------------------------------------------
// intirvx_issue_fifo
// Generic DEPTH-entry synchronous FIFO with flush. Head data is the storage
// entry at the read pointer, so a pushed word is visible the cycle after the
// push. Flush empties the FIFO and wins over a push in the same cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        drop all entries
//   push_i/data_i  write request and data (ignored when full)
//   pop_i          remove head (ignored when empty)
//   data_o         head entry
//   empty_o/full_o occupancy flags, from registered occupancy only
// ----------------------------------------------------------------------------
module intirvx_issue_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_FULL);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage; cleared on reset so the head payload reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/intirvx_issue_dispatch.sv
// ----------------------------------------------------------------------------
// intirvx_issue_dispatch
// Buffers decoded instructions and routes each head entry to the ALU, LSU or
// CSR unit via valid/ready. System entries (fence, fence.i, ecall, ebreak,
// mret, illegal) wait for all outstanding work to complete, then either pulse
// fence_o / fence_i_o or hold a trap request until acknowledged.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush_i                      empty the buffer and return to IDLE
//   in_valid_i/in_ready_o        decoder handshake
//   in_decode_i/in_pc_i/in_inst_i  decoded instruction, PC, raw instruction
//   out_decode_o/out_pc_o/out_inst_o  head payload shared by all units
//   {alu,lsu,csr}_valid_o/_ready_i    unit handshakes
//   done_i                       completion pulses [0] ALU [1] LSU [2] CSR
//   fence_o, fence_i_o           one-cycle retire pulses
//   trap_valid_o/trap_kind_o/trap_pc_o/trap_ack_i  trap request
// ----------------------------------------------------------------------------
module intirvx_issue_dispatch
    import intirvx_issue_dispatch_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  decode_bus   in_decode_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_inst_i,
    output decode_bus   out_decode_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    output logic        alu_valid_o,
    input  logic        alu_ready_i,
    output logic        lsu_valid_o,
    input  logic        lsu_ready_i,
    output logic        csr_valid_o,
    input  logic        csr_ready_i,
    input  logic [2:0]  done_i,
    output logic        fence_o,
    output logic        fence_i_o,
    output logic        trap_valid_o,
    output logic [1:0]  trap_kind_o,
    output logic [31:0] trap_pc_o,
    input  logic        trap_ack_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam int ENTRY_W = $bits(issue_entry_t);

    issue_entry_t     in_entry_s;
    issue_entry_t     head_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;

    disp_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fence_q;
    logic             fence_i_q;
    trap_kind_e       trap_kind_q;
    logic [31:0]      trap_pc_q;

    logic             head_sys_s;
    logic             head_fence_s;
    logic             alu_valid_s;
    logic             lsu_valid_s;
    logic             csr_valid_s;
    logic             issue_s;
    logic             drained_s;
    logic             fence_retire_s;
    logic             trap_retire_s;

    assign in_entry_s = '{dec: in_decode_i, pc: in_pc_i, inst: in_inst_i};
    // Ready depends only on registered occupancy.
    assign in_ready_o = !fifo_full_s;
    assign push_s     = in_valid_i && !fifo_full_s;

    intirvx_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (push_s),
        .data_i  (in_entry_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Head classification, unit valids and pop decision; all derived from
    // registered state, so the valids never depend on the ready inputs.
    always_comb begin
        head_sys_s     = 1'b0;
        head_fence_s   = 1'b0;
        alu_valid_s    = 1'b0;
        lsu_valid_s    = 1'b0;
        csr_valid_s    = 1'b0;
        if (!fifo_empty_s) begin
            head_sys_s   = is_sys(head_s.dec);
            head_fence_s = head_s.dec.fence && !is_trap(head_s.dec);
        end else begin
            head_sys_s   = 1'b0;
            head_fence_s = 1'b0;
        end
        if ((state_q == ST_IDLE) && !fifo_empty_s && !head_sys_s) begin
            case (head_s.dec.unit)
                UNIT_ALU: alu_valid_s = (cnt_q < CNT_MAX);
                UNIT_LSU: lsu_valid_s = (cnt_q < CNT_MAX);
                // CSR access serializes: nothing else may be in flight.
                UNIT_CSR: csr_valid_s = (cnt_q == CNT_ZERO);
                default: begin
                    alu_valid_s = 1'b0;
                    lsu_valid_s = 1'b0;
                    csr_valid_s = 1'b0;
                end
            endcase
        end else begin
            alu_valid_s = 1'b0;
            lsu_valid_s = 1'b0;
            csr_valid_s = 1'b0;
        end
        issue_s = (alu_valid_s && alu_ready_i) ||
                  (lsu_valid_s && lsu_ready_i) ||
                  (csr_valid_s && csr_ready_i);
        drained_s      = (state_q == ST_DRAIN) && !fifo_empty_s && (cnt_q == CNT_ZERO);
        fence_retire_s = drained_s && head_fence_s;
        trap_retire_s  = (state_q == ST_TRAP) && trap_ack_i;
        pop_s          = issue_s || fence_retire_s || trap_retire_s;
    end

    // Outstanding count; a handshake in a flush cycle still counts because
    // the unit will report completion for it.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(issue_s) - CNT_W'(popcount3(done_i));
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Serialization FSM with registered fence pulses and trap request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fence_q     <= 1'b0;
            fence_i_q   <= 1'b0;
            trap_kind_q <= TRAP_ILLEGAL;
            trap_pc_q   <= 32'h0000_0000;
        end else begin
            fence_q   <= 1'b0;
            fence_i_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (head_sys_s) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drained_s) begin
                            if (head_fence_s) begin
                                fence_q   <= !head_s.dec.imm;
                                fence_i_q <= head_s.dec.imm;
                                state_q   <= ST_IDLE;
                            end else begin
                                trap_kind_q <= trap_kind_of(head_s.dec);
                                trap_pc_q   <= head_s.pc;
                                state_q     <= ST_TRAP;
                            end
                        end
                    end
                    ST_TRAP: begin
                        if (trap_ack_i) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign alu_valid_o  = alu_valid_s;
    assign lsu_valid_o  = lsu_valid_s;
    assign csr_valid_o  = csr_valid_s;
    assign out_decode_o = head_s.dec;
    assign out_pc_o     = head_s.pc;
    assign out_inst_o   = head_s.inst;
    assign fence_o      = fence_q;
    assign fence_i_o    = fence_i_q;
    assign trap_valid_o = (state_q == ST_TRAP);
    assign trap_kind_o  = trap_kind_q;
    assign trap_pc_o    = trap_pc_q;

    intirvx_issue_dispatch_chk #(
        .CNT_W (CNT_W),
        .PAY_W (ENTRY_W)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .cnt_i       (cnt_q),
        .done_i      (done_i),
        .alu_valid_i (alu_valid_s),
        .alu_ready_i (alu_ready_i),
        .lsu_valid_i (lsu_valid_s),
        .lsu_ready_i (lsu_ready_i),
        .csr_valid_i (csr_valid_s),
        .csr_ready_i (csr_ready_i),
        .payload_i   (head_s)
    );

endmodule
